// File: rtl/hazard_pkg.sv
// Shared types for the R/C/M/W hazard controller.
// Forward-select encodings and controller FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE    = 2'd0,
        FWD_COMPUTE = 2'd1,
        FWD_W       = 2'd2,
        FWD_POSTW   = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        LISTEN     = 1'b0,
        LOAD_STALL = 1'b1
    } haz_state_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/hazard_src_match.sv
// One source operand's hazard check against the C and M stage writers.
// Produces the raw forward select and a load-use flag.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int ADR_W = 5
) (
    input  logic [ADR_W-1:0] rs_adr_i,
    input  logic             rs_used_i,
    input  logic [ADR_W-1:0] rd_c_i,
    input  logic [ADR_W-1:0] rd_m_i,
    input  logic             we_c_i,
    input  logic             we_m_i,
    input  logic             mem_rd_c_i,
    output fwd_sel_t         sel_o,
    output logic             load_haz_o
);

    logic match_c;
    logic match_m;

    assign match_c = rs_used_i & we_c_i & (rd_c_i != '0)
                   & (rs_adr_i == rd_c_i);
    assign match_m = rs_used_i & we_m_i & (rd_m_i != '0)
                   & (rs_adr_i == rd_m_i);

    // The younger C-stage writer wins over M.
    always_comb begin
        sel_o      = FWD_NONE;
        load_haz_o = 1'b0;
        if (match_c && mem_rd_c_i) begin
            sel_o      = FWD_W;
            load_haz_o = 1'b1;
        end else if (match_c) begin
            sel_o = FWD_COMPUTE;
        end else if (match_m) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding/stall controller for NUM_SRC operands with LOAD_LAT load-use stalls.
// Define HAZ_BRANCH_FLUSH_EN to add branch-flush arbitration (BranchTaken_C, FlushIR, FlushRC).
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int ADR_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*ADR_W-1:0] rsAdr_R,
    input  logic [NUM_SRC-1:0]       rsUsed_R,
    input  logic [ADR_W-1:0]         rdAdr_C,
    input  logic [ADR_W-1:0]         rdAdr_M,
    input  logic                     RegWrite_C,
    input  logic                     RegWrite_M,
    input  logic                     MemRead_C,
`ifdef HAZ_BRANCH_FLUSH_EN
    input  logic                     BranchTaken_C,
    output logic                     FlushIR,
    output logic                     FlushRC,
`endif
    output logic [NUM_SRC*2-1:0]     FwdSel_C,
    output logic                     FlushCM,
    output logic                     StallPC,
    output logic                     StallIR,
    output logic                     StallRC
);

    haz_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SRC*2-1:0] fwd_q, fwd_d;
    fwd_sel_t             raw_sel [NUM_SRC];
    logic [NUM_SRC-1:0]   load_haz;
    logic                 stall;
    logic                 load_any;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src_match #(
            .ADR_W(ADR_W)
        ) u_match (
            .rs_adr_i  (rsAdr_R[g*ADR_W +: ADR_W]),
            .rs_used_i (rsUsed_R[g]),
            .rd_c_i    (rdAdr_C),
            .rd_m_i    (rdAdr_M),
            .we_c_i    (RegWrite_C),
            .we_m_i    (RegWrite_M),
            .mem_rd_c_i(MemRead_C),
            .sel_o     (raw_sel[g]),
            .load_haz_o(load_haz[g])
        );
    end

    assign load_any = |load_haz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fwd_d   = fwd_q;
        stall   = 1'b0;
`ifdef HAZ_BRANCH_FLUSH_EN
        FlushIR = 1'b0;
        FlushRC = 1'b0;
`endif
        unique case (state_q)
            LISTEN: begin
                // M-stage values retire to the regfile while the load stalls.
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (load_any && raw_sel[i] == FWD_W && !load_haz[i])
                        fwd_d[i*2 +: 2] = FWD_POSTW;
                    else
                        fwd_d[i*2 +: 2] = raw_sel[i];
                end
                if (load_any) begin
                    state_d = LOAD_STALL;
                    cnt_d   = CNT_W'(LOAD_LAT - 1);
                end
            end
            LOAD_STALL: begin
                stall = 1'b1;
                if (cnt_q != '0)
                    cnt_d = cnt_q - 1'b1;
                else
                    state_d = LISTEN;
            end
            default: state_d = LISTEN;
        endcase
`ifdef HAZ_BRANCH_FLUSH_EN
        if (BranchTaken_C) begin
            FlushIR = 1'b1;
            FlushRC = 1'b1;
            stall   = 1'b0;
            state_d = LISTEN;
            cnt_d   = '0;
            fwd_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LISTEN;
            cnt_q   <= '0;
            fwd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_q   <= fwd_d;
        end
    end

    assign FwdSel_C = fwd_q;
    assign StallPC  = stall;
    assign StallIR  = stall;
    assign StallRC  = stall;
    assign FlushCM  = stall;

endmodule
